// File: rtl/cpu_datamem_blk_wr.sv
// Block-write sequencer: splits one NWORDS x 32-bit block into sequential word writes on the shared data-memory port, always yielding to CPU writes.
// Optional macro CPU_DATAMEM_BLK_WR_BSWAP_EN byte-reverses every word before it is written (big-endian host layout).
module cpu_datamem_blk_wr #(
  parameter int                NWORDS   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] MAX_BASE = 16'hFFC0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [32*NWORDS-1:0]   req_data,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [31:0]            cpu_wrt_data,
  input  logic                   cpu_wrt_en,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wrt_data,
  output logic                   mem_wrt_en
);

  localparam int              CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [32*NWORDS-1:0] blk_q, blk_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [31:0]          blk_words [NWORDS];
  logic [ADDR_W-1:0]    seq_addr;
  logic                 in_write;
  logic                 seq_go;

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
`ifdef CPU_DATAMEM_BLK_WR_BSWAP_EN
      assign blk_words[gi] = {blk_q[32*gi +: 8], blk_q[32*gi+8 +: 8],
                              blk_q[32*gi+16 +: 8], blk_q[32*gi+24 +: 8]};
`else
      assign blk_words[gi] = blk_q[32*gi +: 32];
`endif
    end
  endgenerate

  // rst gates everything combinational so an abort takes effect in the reset cycle itself.
  assign in_write = (state_q == S_WRITE) && !rst;
  assign seq_go   = in_write && !cpu_wrt_en;
  assign seq_addr = base_q + ADDR_W'({cnt_q, 2'b00});

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign busy      = in_write;
  assign done      = done_q && !rst;
  assign err       = err_q && !rst;

  always_comb begin
    if (seq_go) begin
      mem_addr     = seq_addr;
      mem_wrt_data = blk_words[cnt_q];
      mem_wrt_en   = 1'b1;
    end else begin
      mem_addr     = cpu_addr;
      mem_wrt_data = cpu_wrt_data;
      mem_wrt_en   = cpu_wrt_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    blk_d   = blk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d = req_addr;
          blk_d  = req_data;
          if (req_addr > MAX_BASE) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!cpu_wrt_en) begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Block payload is only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    blk_q  <= blk_d;
  end

endmodule

// File: tb/tb_cpu_datamem_blk_wr.sv
// Directed bench for cpu_datamem_blk_wr: scoreboard of expected memory-port writes plus a byte-wide memory model for readback.
module tb_cpu_datamem_blk_wr;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [15:0]  req_addr;
  logic [511:0] req_data;
  logic         done, err, busy;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wrt_data;
  logic         cpu_wrt_en;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wrt_data;
  logic         mem_wrt_en;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] seq_q [$];
  logic [47:0] cpu_q [$];
  logic [7:0]  mem [65536];
  bit          mem_init_done = 1'b0;

  cpu_datamem_blk_wr dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .done(done), .err(err), .busy(busy),
    .cpu_addr(cpu_addr), .cpu_wrt_data(cpu_wrt_data), .cpu_wrt_en(cpu_wrt_en),
    .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stored 32-bit image of a host word (memory is little-endian).
  function automatic logic [31:0] img(input logic [31:0] w);
`ifdef CPU_DATAMEM_BLK_WR_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [511:0] blk_img(input logic [511:0] d);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = img(d[32*i +: 32]);
    return r;
  endfunction

  function automatic logic [511:0] rd_blk(input int a);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = mem[a + i];
    return r;
  endfunction

  function automatic logic [31:0] rd32(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Memory model; pre-loads "old" contents once during the first reset.
  always @(posedge clk) begin
    if (rst && !mem_init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] = (i >= 32'h5000 && i < 32'h5040) ? 8'h5A : 8'h00;
      mem_init_done = 1'b1;
    end else if (mem_wrt_en) begin
      for (int b = 0; b < 4; b++) mem[16'(mem_addr + 16'(b))] = mem_wrt_data[8*b +: 8];
    end
  end

  // Port monitor: every write must match the next expected CPU or sequencer write.
  always @(negedge clk) begin
    if (cpu_wrt_en) begin
      check("cpu_pass_en", {63'd0, mem_wrt_en}, 64'd1);
      if (cpu_q.size() > 0) check("cpu_pass_write", {16'd0, mem_addr, mem_wrt_data}, {16'd0, cpu_q.pop_front()});
    end else if (mem_wrt_en) begin
      if (seq_q.size() > 0) check("seq_write", {16'd0, mem_addr, mem_wrt_data}, {16'd0, seq_q.pop_front()});
      else check("seq_unexpected_write", {63'd0, mem_wrt_en}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [15:0] a, input logic [511:0] d);
    for (int i = 0; i < 16; i++) seq_q.push_back({a + 16'(4*i), img(d[32*i +: 32])});
  endtask

  task automatic start_req(input logic [15:0] a, input logic [511:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    push_block(a, d);
    @(negedge clk);
    check("accept_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    $display("request accepted addr=%h", a);
  endtask

  // Runs from the cycle after accept; CPU writes 0xDEADBEEF to 0x9000 in WRITE cycles ca and cb.
  task automatic wait_done(input string tag, input int exp_lat, input int ca, input int cb);
    int lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == ca || k == cb) begin
        cpu_wrt_en   = 1'b1;
        cpu_addr     = 16'h9000;
        cpu_wrt_data = 32'hDEADBEEF;
        cpu_q.push_back({16'h9000, 32'hDEADBEEF});
      end else begin
        cpu_wrt_en = 1'b0;
      end
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        check({tag, "_ready_low"}, {63'd0, req_ready}, 64'd0);
      end
      if (done) begin
        lat = k;
        check({tag, "_err_with_done"}, {63'd0, err}, 64'd0);
      end
      tick();
      if (lat >= 0) break;
    end
    cpu_wrt_en = 1'b0;
    check({tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check({tag, "_done_single"}, {63'd0, done}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
    tick();
    $display("block %s done latency=%0d", tag, lat);
  endtask

  initial begin
    logic [511:0] d1, da, db, d4, d6;
    int dc;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    cpu_addr = '0; cpu_wrt_data = '0; cpu_wrt_en = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    tick();

    // 1: plain block, no contention
    for (int i = 0; i < 16; i++) d1[32*i +: 32] = 32'(32'h01010101 * i);
    start_req(16'h1000, d1);
    wait_done("t1", 17, 0, 0);
    check("t1_readback", 64'(rd_blk(32'h1000) != blk_img(d1)), 64'd0);
    check("t1_word15", {32'd0, rd32(32'h103C)}, {32'd0, img(32'h0F0F0F0F)});

    // 2: CPU writes steal WRITE cycles 3 and 7
    for (int i = 0; i < 64; i++) mem[32'h1000 + i] = 8'h00;
    start_req(16'h1000, d1);
    wait_done("t2", 19, 3, 7);
    check("t2_readback", 64'(rd_blk(32'h1000) != blk_img(d1)), 64'd0);
    check("t2_cpu_word", {32'd0, rd32(32'h9000)}, 64'hDEADBEEF);

    // 3: illegal base rejected, highest legal base accepted
    req_valid = 1'b1; req_addr = 16'hFFC1; req_data = d1;
    @(negedge clk);
    check("t3_ready_before", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("t3_err_pulse", {63'd0, err}, 64'd1);
    check("t3_err_no_write", {63'd0, mem_wrt_en}, 64'd0);
    check("t3_err_ready", {63'd0, req_ready}, 64'd1);
    check("t3_err_busy", {63'd0, busy}, 64'd0);
    tick();
    @(negedge clk);
    check("t3_err_once", {63'd0, err}, 64'd0);
    $display("request addr=ffc1 rejected");
    tick();
    start_req(16'hFFC0, d1);
    wait_done("t3_max", 17, 0, 0);
    check("t3_readback", 64'(rd_blk(32'hFFC0) != blk_img(d1)), 64'd0);

    // 4: reset after 5 words
    for (int i = 0; i < 16; i++) d4[32*i +: 32] = 32'hC0DE0000 | 32'(i);
    start_req(16'h5000, d4);
    repeat (5) tick();
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_no_write", {63'd0, mem_wrt_en}, 64'd0);
    check("t4_rst_busy", {63'd0, busy}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4_ready_after_rst", {63'd0, req_ready}, 64'd1);
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
    tick();
    check("t4_no_done", 64'(dc), 64'd0);
    check("t4_words_left", 64'(seq_q.size()), 64'd11);
    seq_q.delete();
    check("t4_word4_new", {32'd0, rd32(32'h5010)}, {32'd0, img(32'hC0DE0004)});
    check("t4_word5_old", {32'd0, rd32(32'h5014)}, 64'h5A5A5A5A);
    $display("reset abort after 5 words checked");

    // 5: second request held during WRITE, accepted right after done
    for (int i = 0; i < 16; i++) begin
      da[32*i +: 32] = $urandom;
      db[32*i +: 32] = $urandom;
    end
    start_req(16'h2000, da);
    req_valid = 1'b1; req_addr = 16'h2040; req_data = db;
    push_block(16'h2040, db);
    wait_done("t5_a", 17, 0, 0);
    req_valid = 1'b0;
    wait_done("t5_b", 17, 0, 0);
    check("t5_a_readback", 64'(rd_blk(32'h2000) != blk_img(da)), 64'd0);
    check("t5_b_readback", 64'(rd_blk(32'h2040) != blk_img(db)), 64'd0);

    // 6: byte order of word 0
    d6 = '0;
    d6[31:0] = 32'hAABBCCDD;
    start_req(16'h6000, d6);
    wait_done("t6", 17, 0, 0);
`ifdef CPU_DATAMEM_BLK_WR_BSWAP_EN
    check("t6_bytes", {32'd0, mem[32'h6000], mem[32'h6001], mem[32'h6002], mem[32'h6003]}, 64'hAABBCCDD);
`else
    check("t6_bytes", {32'd0, mem[32'h6000], mem[32'h6001], mem[32'h6002], mem[32'h6003]}, 64'hDDCCBBAA);
`endif

    check("end_seq_queue", 64'(seq_q.size()), 64'd0);
    check("end_cpu_queue", 64'(cpu_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_datamem_blk_wr.md
Name: cpu_datamem_blk_wr

Overview:
- Block-write sequencer directly upstream of the CPU data memory write port.
- Accepts one 64-byte (512-bit) block from the host-communication side and writes it as 16 sequential 4-byte writes, since the data memory accepts only 32-bit writes.
- Shares the single memory address/write port with the CPU. The CPU always has priority.
- Used to fill HCB/ACB regions (0x1000–0x8100) that the accelerator later reads back as one 512-bit word.

Parameters:
- NWORDS, 16, number of 32-bit words per block (block bytes = 4*NWORDS).
- ADDR_W, 16, memory address width.
- MAX_BASE, 16'hFFC0, highest legal block base address (65536 - 4*NWORDS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  block write request
- req_ready  out  1  sequencer can accept a request
- req_addr  in  ADDR_W  block base byte address
- req_data  in  32*NWORDS  block data; word i = req_data[32*i+31:32*i]
- done  out  1  one-cycle pulse: all words written
- err  out  1  one-cycle pulse: request rejected (illegal base)
- busy  out  1  sequencer owns or contends for the memory port
- cpu_addr  in  ADDR_W  CPU address
- cpu_wrt_data  in  32  CPU write data
- cpu_wrt_en  in  1  CPU write enable
- mem_addr  out  ADDR_W  to data memory addr
- mem_wrt_data  out  32  to data memory wrt_data
- mem_wrt_en  out  1  to data memory wrt_en

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, WRITE, DONE. Reset forces IDLE, cnt=0, done=0, err=0, busy=0.
- Memory port outputs:
  - mem_wrt_en, mem_addr and mem_wrt_data are combinational.
  - req_ready = (state==IDLE) and !rst.
- IDLE:
  - On req_valid && req_ready, latch req_addr into base and req_data into blk.
  - If req_addr > MAX_BASE, pulse err next cycle, stay IDLE, perform no writes.
  - Otherwise set cnt=0 and go to WRITE.
  - Unaligned base addresses are legal.
- WRITE:
  - Sequencer address = base + 4*cnt; sequencer data = blk word cnt.
  - If cpu_wrt_en=1: memory port carries the CPU write. The sequencer stalls and cnt holds.
  - If cpu_wrt_en=0: memory port carries the sequencer write with mem_wrt_en=1, and cnt increments.
  - When word NWORDS-1 is written, go to DONE.
  - busy=1 throughout WRITE.
- DONE: done=1 for exactly one cycle, then IDLE. req_ready returns the following cycle.
- Outside WRITE: mem_addr=cpu_addr, mem_wrt_data=cpu_wrt_data, mem_wrt_en=cpu_wrt_en (pure pass-through, so CPU reads work).
- CPU reads during WRITE are not supported, because mem_addr carries the sequencer address. The CPU must honour busy.
- Latency with no contention:
  - Accept at cycle T; writes at T+1 through T+16.
  - done at T+17; req_ready at T+18.
  - Each CPU-write cycle during WRITE adds exactly one cycle.
- Address arithmetic: ADDR_W bits. The MAX_BASE check guarantees base+4*cnt+3 never wraps.
- Reset mid-operation: abort immediately. No further writes, no done pulse. Words already written remain in memory.
- New requests during WRITE/DONE: ignored (req_ready=0). The requester must hold req_valid.
- done and err are mutually exclusive and never assert in the same cycle.

Optional Feature:
- Macro: CPU_DATAMEM_BLK_WR_BSWAP_EN.
- When defined: each 32-bit word is byte-reversed before writing, so a big-endian host word 0xAABBCCDD is stored as bytes AA, BB, CC, DD at addr..addr+3.
- When undefined: words are written unchanged (little-endian), so 0xAABBCCDD is stored as DD, CC, BB, AA.

Test Plan:
1. Reset, then req_addr=0x1000 with word i = 0x01010101*i, no CPU traffic.
   -> mem_wrt_en high 16 cycles, addresses 0x1000, 0x1004 ... 0x103C; done at T+17.
   -> 512-bit memory read at 0x1000 returns req_data.
2. Same request; cpu_wrt_en=1 at WRITE cycles 3 and 7, writing 0xDEADBEEF to 0x9000.
   -> both CPU writes land; sequencer words unaffected; done at T+19.
3. req_addr=0xFFC1 -> err pulses once, no mem_wrt_en, req_ready stays 1. req_addr=0xFFC0 -> accepted, last write at 0xFFFC.
4. rst asserted after 5 words written.
   -> writes stop, no done; 0x5000–0x5013 hold new data, 0x5014+ keep old data; req_ready=1 after reset.
5. req_valid held high during WRITE with a second block.
   -> ignored until IDLE; second block accepted the cycle after done; back-to-back blocks correct.
6. With CPU_DATAMEM_BLK_WR_BSWAP_EN, word 0 = 0xAABBCCDD at 0x6000.
   -> bytes 0x6000..0x6003 = AA, BB, CC, DD. Without the macro: DD, CC, BB, AA.
